// File: rtl/regscan_pkg.sv
// Shared types and default widths for the register-file scan controller.
package regscan_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_IDX_W  = 5;
  localparam int DEFAULT_GAP_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_SEND = 3'd2,
    S_SUM  = 3'd3,
    S_DONE = 3'd4,
    S_GAP  = 3'd5
  } regscan_state_e;

endpackage

// File: rtl/regscan_gap_timer.sv
// Loadable down-counter with a zero flag; paces the idle gap between auto scans.
module regscan_gap_timer
  import regscan_pkg::*;
#(
  parameter int GAP_W = DEFAULT_GAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [GAP_W-1:0] load_val,
  output logic             zero
);

  logic [GAP_W-1:0] count_r;

  // Count register: load has priority, decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {GAP_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {GAP_W{1'b0}})) begin
      count_r <= count_r - {{(GAP_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {GAP_W{1'b0}});

endmodule

// File: rtl/regfile_scan_controller.sv
// Streams a (possibly wrapping) register range from the register file's aux read port.
// Optional trailing XOR checksum word: define REGSCAN_CHECKSUM_EN.
module regfile_scan_controller
  import regscan_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int IDX_W  = DEFAULT_IDX_W,
  parameter int GAP_W  = DEFAULT_GAP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  first_reg,
  input  logic [IDX_W-1:0]  last_reg,
  input  logic              auto_mode,
  input  logic [GAP_W-1:0]  gap_cycles,
  output logic [IDX_W-1:0]  rf_sel,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_sum,
  output logic              busy,
  output logic              done
);

  regscan_state_e    state_r, state_nx_s;
  logic [IDX_W-1:0]  idx_r, last_q_r, out_index_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_valid_r, out_last_r, busy_r, done_r;
  logic              hs_s, accept_s, capture_s, advance_s, enter_done_s;
  logic              gap_load_s, gap_dec_s, gap_zero_s;
`ifdef REGSCAN_CHECKSUM_EN
  logic [DATA_W-1:0] csum_r;
  logic              out_sum_r, enter_sum_s;
`endif

  assign hs_s = out_valid_r && out_ready;

  regscan_gap_timer #(.GAP_W(GAP_W)) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load_s),
    .dec      (gap_dec_s),
    .load_val (gap_cycles - {{(GAP_W-1){1'b0}}, 1'b1}),
    .zero     (gap_zero_s)
  );

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nx_s   = state_r;
    accept_s     = 1'b0;
    capture_s    = 1'b0;
    advance_s    = 1'b0;
    enter_done_s = 1'b0;
    gap_load_s   = 1'b0;
    gap_dec_s    = 1'b0;
`ifdef REGSCAN_CHECKSUM_EN
    enter_sum_s  = 1'b0;
`endif
    case (state_r)
      S_IDLE: begin
        if (start) begin
          accept_s   = 1'b1;
          state_nx_s = S_READ;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_READ: begin
        capture_s  = 1'b1;
        state_nx_s = S_SEND;
      end
      S_SEND: begin
        if (hs_s && (idx_r != last_q_r)) begin
          advance_s  = 1'b1;
          state_nx_s = S_READ;
        end else if (hs_s) begin
`ifdef REGSCAN_CHECKSUM_EN
          enter_sum_s  = 1'b1;
          state_nx_s   = S_SUM;
`else
          enter_done_s = 1'b1;
          state_nx_s   = S_DONE;
`endif
        end else begin
          state_nx_s = S_SEND;
        end
      end
`ifdef REGSCAN_CHECKSUM_EN
      S_SUM: begin
        if (hs_s) begin
          enter_done_s = 1'b1;
          state_nx_s   = S_DONE;
        end else begin
          state_nx_s = S_SUM;
        end
      end
`endif
      S_DONE: begin
        if (auto_mode && (gap_cycles == {GAP_W{1'b0}})) begin
          accept_s   = 1'b1;
          state_nx_s = S_READ;
        end else if (auto_mode) begin
          gap_load_s = 1'b1;
          state_nx_s = S_GAP;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_GAP: begin
        if (!auto_mode) begin
          state_nx_s = S_IDLE;
        end else if (gap_zero_s) begin
          accept_s   = 1'b1;
          state_nx_s = S_READ;
        end else begin
          gap_dec_s  = 1'b1;
          state_nx_s = S_GAP;
        end
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State, scan index and registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      idx_r       <= {IDX_W{1'b0}};
      last_q_r    <= {IDX_W{1'b0}};
      out_index_r <= {IDX_W{1'b0}};
      out_data_r  <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      done_r  <= enter_done_s;
      if (accept_s) begin
        idx_r    <= first_reg;
        last_q_r <= last_reg;
        busy_r   <= 1'b1;
      end else if (advance_s) begin
        idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
      end else if (enter_done_s) begin
        busy_r <= 1'b0;
      end
      if (capture_s) begin
        out_data_r  <= rf_data;
        out_index_r <= idx_r;
        out_valid_r <= 1'b1;
`ifdef REGSCAN_CHECKSUM_EN
        out_last_r  <= 1'b0;
`else
        out_last_r  <= (idx_r == last_q_r);
`endif
`ifdef REGSCAN_CHECKSUM_EN
      end else if (enter_sum_s) begin
        // Final register word is folded in on the same edge it handshakes.
        out_data_r  <= csum_r ^ out_data_r;
        out_index_r <= last_q_r;
        out_last_r  <= 1'b1;
        out_valid_r <= 1'b1;
`endif
      end else if (hs_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

`ifdef REGSCAN_CHECKSUM_EN
  // Running XOR of handshaken register words and the checksum-word marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_r    <= {DATA_W{1'b0}};
      out_sum_r <= 1'b0;
    end else begin
      if (accept_s) begin
        csum_r <= {DATA_W{1'b0}};
      end else if (hs_s && (state_r == S_SEND)) begin
        csum_r <= csum_r ^ out_data_r;
      end
      if (enter_sum_s) begin
        out_sum_r <= 1'b1;
      end else if (capture_s || hs_s) begin
        out_sum_r <= 1'b0;
      end
    end
  end
  assign out_sum = out_sum_r;
`else
  assign out_sum = 1'b0;
`endif

  assign rf_sel    = idx_r;
  assign out_valid = out_valid_r;
  assign out_index = out_index_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule
